// File: rtl/cpu_ex_md.sv
// Execute stage: single-cycle ALU path plus an iterative RV32M multiply/divide
// unit, valid/ready handshaking upstream and downstream, async forwarding to decode.
package cpu_ex_md_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_mode_t;
    typedef enum logic [1:0] {MA_X, MA_LD, MA_ST} ma_mode_t;
    typedef enum logic [2:0] {MA_B, MA_H, MA_W, MA_BU, MA_HU} ma_size_t;
    typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_MEM, WB_SRC_CSR} wb_src_t;

    localparam ma_mode_t NOP_MA_MODE  = MA_X;
    localparam ma_size_t NOP_MA_SIZE  = MA_W;
    localparam wb_src_t  NOP_WB_SRC   = WB_SRC_ALU;
    localparam logic     NOP_WB_VALID = 1'b0;
endpackage

module cpu_ex_md
    import cpu_ex_md_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              MD_STEP = 1,
    parameter logic [XLEN-1:0] NOP_PC  = {XLEN{1'b1}}
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] ir_i,
    input  logic [XLEN-1:0] alu_op1_i,
    input  logic [XLEN-1:0] alu_op2_i,
    input  alu_mode_t       alu_mode_i,
    input  logic            md_en_i,
    input  logic [2:0]      md_op_i,
    input  ma_mode_t        ma_mode_i,
    input  ma_size_t        ma_size_i,
    input  logic [XLEN-1:0] ma_data_i,
    input  wb_src_t         wb_src_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            wb_valid_i,
    output logic [4:0]      wb_addr_async_o,
    output logic [XLEN-1:0] wb_data_async_o,
    output logic            wb_ready_async_o,
    output logic            wb_valid_async_o,
    output logic            empty_async_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ir_o,
    output logic [XLEN-1:0] ma_addr_o,
    output ma_mode_t        ma_mode_o,
    output ma_size_t        ma_size_o,
    output logic [XLEN-1:0] ma_data_o,
    output wb_src_t         wb_src_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_valid_o
);
    localparam int NSTEP = XLEN / MD_STEP;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam int SW    = $clog2(XLEN);
    localparam logic [XLEN-1:0] NOP_IR = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] SMIN   = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        md_op_reg;
    logic              neg_q_reg, neg_r_reg;
    logic [2*XLEN-1:0] acc_reg, mcand_reg;
    logic [XLEN-1:0]   mplier_reg, md_res_reg;
    logic [XLEN-1:0]   pc_reg, ir_reg, op1_reg, op2_reg, ma_data_reg, wb_data_reg;
    alu_mode_t         alu_mode_reg;
    ma_mode_t          ma_mode_reg;
    ma_size_t          ma_size_reg;
    wb_src_t           wb_src_reg;
    logic              wb_valid_reg;

    logic            idle, out_en, accept;
    logic [XLEN-1:0] cur_op1, cur_op2, cur_pc, cur_ir, cur_ma_data, cur_wb_data;
    alu_mode_t       cur_alu_mode;
    ma_mode_t        cur_ma_mode;
    ma_size_t        cur_ma_size;
    wb_src_t         cur_wb_src;
    logic            cur_wb_valid, cur_valid;

    assign idle    = (state_reg == ST_IDLE);
    assign out_en  = !valid_o || ready_i;
    assign ready_o = idle && out_en;
    assign accept  = valid_i && ready_o && !flush_i;

    // In IDLE the stage looks at its inputs; otherwise at the latched MD instruction.
    always_comb begin
        if (idle) begin
            cur_op1 = alu_op1_i;  cur_op2 = alu_op2_i;  cur_alu_mode = alu_mode_i;
            cur_pc = pc_i;  cur_ir = ir_i;  cur_ma_mode = ma_mode_i;  cur_ma_size = ma_size_i;
            cur_ma_data = ma_data_i;  cur_wb_src = wb_src_i;  cur_wb_data = wb_data_i;
            cur_wb_valid = wb_valid_i;  cur_valid = valid_i;
        end else begin
            cur_op1 = op1_reg;  cur_op2 = op2_reg;  cur_alu_mode = alu_mode_reg;
            cur_pc = pc_reg;  cur_ir = ir_reg;  cur_ma_mode = ma_mode_reg;  cur_ma_size = ma_size_reg;
            cur_ma_data = ma_data_reg;  cur_wb_src = wb_src_reg;  cur_wb_data = wb_data_reg;
            cur_wb_valid = wb_valid_reg;  cur_valid = 1'b1;
        end
    end

    logic [XLEN-1:0] alu_res;
    logic [SW-1:0]   shamt;
    assign shamt = cur_op2[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (cur_alu_mode)
            ALU_ADD:  alu_res = cur_op1 + cur_op2;
            ALU_SUB:  alu_res = cur_op1 - cur_op2;
            ALU_SLL:  alu_res = cur_op1 << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(cur_op1) < $signed(cur_op2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, cur_op1 < cur_op2};
            ALU_XOR:  alu_res = cur_op1 ^ cur_op2;
            ALU_SRL:  alu_res = cur_op1 >> shamt;
            ALU_SRA:  alu_res = $signed(cur_op1) >>> shamt;
            ALU_OR:   alu_res = cur_op1 | cur_op2;
            ALU_AND:  alu_res = cur_op1 & cur_op2;
            default:  alu_res = '0;
        endcase
    end

    // Operand preparation: the iterative core works on magnitudes only.
    logic            is_div_in, s1_in, s2_in, neg1_in, neg2_in, div_zero, div_ovf, corner;
    logic [XLEN-1:0] mag1_in, mag2_in, corner_res;

    assign is_div_in = md_op_i[2];
    assign s1_in     = (md_op_i == 3'd1) || (md_op_i == 3'd2) || (md_op_i[2] && !md_op_i[0]);
    assign s2_in     = (md_op_i == 3'd1) || (md_op_i[2] && !md_op_i[0]);
    assign neg1_in   = s1_in && alu_op1_i[XLEN-1];
    assign neg2_in   = s2_in && alu_op2_i[XLEN-1];
    assign mag1_in   = neg1_in ? -alu_op1_i : alu_op1_i;
    assign mag2_in   = neg2_in ? -alu_op2_i : alu_op2_i;
    assign div_zero  = (alu_op2_i == '0);
    assign div_ovf   = s2_in && (alu_op1_i == SMIN) && (alu_op2_i == {XLEN{1'b1}});
    assign corner    = is_div_in && (div_zero || div_ovf);

    always_comb begin
        if (div_zero) corner_res = md_op_i[1] ? alu_op1_i : {XLEN{1'b1}};
        else          corner_res = md_op_i[1] ? '0 : alu_op1_i;
    end

    // MD_STEP iterations of shift-add multiply or restoring divide per BUSY cycle.
    logic [2*XLEN-1:0] acc_step, mcand_step, prod;
    logic [XLEN-1:0]   mplier_step, quo, rem, md_fin;
    logic [XLEN:0]     rem_t;

    always_comb begin
        acc_step    = acc_reg;
        mcand_step  = mcand_reg;
        mplier_step = mplier_reg;
        rem_t       = '0;
        for (int k = 0; k < MD_STEP; k++) begin
            if (md_op_reg[2]) begin
                rem_t       = {acc_step[XLEN-1:0], mplier_step[XLEN-1]};
                mplier_step = {mplier_step[XLEN-2:0], 1'b0};
                if (rem_t >= {1'b0, mcand_step[XLEN-1:0]}) begin
                    rem_t          = rem_t - {1'b0, mcand_step[XLEN-1:0]};
                    mplier_step[0] = 1'b1;
                end
                acc_step = {{XLEN{1'b0}}, rem_t[XLEN-1:0]};
            end else begin
                if (mplier_step[0]) acc_step = acc_step + mcand_step;
                mcand_step  = mcand_step << 1;
                mplier_step = mplier_step >> 1;
            end
        end
    end

    assign prod = neg_q_reg ? -acc_step : acc_step;
    assign quo  = neg_q_reg ? -mplier_step : mplier_step;
    assign rem  = neg_r_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];

    always_comb begin
        if (md_op_reg[2])              md_fin = md_op_reg[1] ? rem : quo;
        else if (md_op_reg[1:0] == 2'd0) md_fin = prod[XLEN-1:0];
        else                           md_fin = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;  cnt_reg <= '0;  md_op_reg <= '0;
            neg_q_reg  <= 1'b0;  neg_r_reg <= 1'b0;
            acc_reg    <= '0;  mcand_reg <= '0;  mplier_reg <= '0;  md_res_reg <= '0;
            pc_reg     <= NOP_PC;  ir_reg <= NOP_IR;  op1_reg <= '0;  op2_reg <= '0;
            alu_mode_reg <= ALU_ADD;  ma_mode_reg <= NOP_MA_MODE;  ma_size_reg <= NOP_MA_SIZE;
            ma_data_reg  <= '0;  wb_src_reg <= NOP_WB_SRC;  wb_data_reg <= '0;
            wb_valid_reg <= NOP_WB_VALID;
        end else if (flush_i) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept && md_en_i) begin
                        pc_reg <= pc_i;  ir_reg <= ir_i;  op1_reg <= alu_op1_i;  op2_reg <= alu_op2_i;
                        alu_mode_reg <= alu_mode_i;  ma_mode_reg <= ma_mode_i;  ma_size_reg <= ma_size_i;
                        ma_data_reg  <= ma_data_i;  wb_src_reg <= wb_src_i;  wb_data_reg <= wb_data_i;
                        wb_valid_reg <= wb_valid_i;  md_op_reg <= md_op_i;
                        neg_q_reg <= neg1_in ^ neg2_in;
                        neg_r_reg <= neg1_in;
                        acc_reg    <= '0;
                        mcand_reg  <= {{XLEN{1'b0}}, is_div_in ? mag2_in : mag1_in};
                        mplier_reg <= is_div_in ? mag1_in : mag2_in;
                        cnt_reg    <= '0;
                        if (corner) begin
                            md_res_reg <= corner_res;
                            state_reg  <= ST_DONE;
                        end else begin
                            state_reg  <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_reg    <= acc_step;
                    mcand_reg  <= mcand_step;
                    mplier_reg <= mplier_step;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(NSTEP - 1)) begin
                        md_res_reg <= md_fin;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE:  if (out_en) state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    logic [XLEN-1:0] res_sel, fwd_data;
    assign res_sel  = (state_reg == ST_DONE) ? md_res_reg : alu_res;
    assign fwd_data = (cur_wb_src == WB_SRC_ALU) ? res_sel : cur_wb_data;

    assign wb_addr_async_o  = cur_ir[11:7];
    assign wb_data_async_o  = fwd_data;
    assign wb_valid_async_o = cur_valid && cur_wb_valid;
    assign empty_async_o    = idle && (!valid_i || (pc_i == NOP_PC));

    // An MD op sitting at the input has no result yet, so it is not forwardable.
    always_comb begin
        case (state_reg)
            ST_BUSY: wb_ready_async_o = 1'b0;
            ST_DONE: wb_ready_async_o = 1'b1;
            default: wb_ready_async_o = (wb_src_i != WB_SRC_MEM) && !(valid_i && md_en_i);
        endcase
    end

    logic            load_real, valid_next, wb_valid_next;
    logic [XLEN-1:0] pc_next, ir_next, ma_addr_next, ma_data_next, wb_data_next;
    ma_mode_t        ma_mode_next;
    ma_size_t        ma_size_next;
    wb_src_t         wb_src_next;

    assign load_real = !flush_i && ((idle && accept && !md_en_i) || (state_reg == ST_DONE));

    always_comb begin
        valid_next = 1'b0;  pc_next = NOP_PC;  ir_next = NOP_IR;  ma_addr_next = '0;
        ma_mode_next = NOP_MA_MODE;  ma_size_next = NOP_MA_SIZE;  ma_data_next = '0;
        wb_src_next = NOP_WB_SRC;  wb_data_next = '0;  wb_valid_next = NOP_WB_VALID;
        if (load_real) begin
            valid_next    = 1'b1;
            pc_next       = cur_pc;
            ir_next       = cur_ir;
            ma_addr_next  = (cur_ma_mode != MA_X) ? alu_res : '0;
            ma_mode_next  = cur_ma_mode;
            ma_size_next  = cur_ma_size;
            ma_data_next  = cur_ma_data;
            wb_src_next   = cur_wb_src;
            wb_data_next  = fwd_data;
            wb_valid_next = cur_wb_valid;
        end
    end

    // Flush forces a bubble into the output register even under back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;  pc_o <= NOP_PC;  ir_o <= NOP_IR;  ma_addr_o <= '0;
            ma_mode_o <= NOP_MA_MODE;  ma_size_o <= NOP_MA_SIZE;  ma_data_o <= '0;
            wb_src_o <= NOP_WB_SRC;  wb_data_o <= '0;  wb_valid_o <= NOP_WB_VALID;
        end else if (flush_i || out_en) begin
            valid_o <= valid_next;  pc_o <= pc_next;  ir_o <= ir_next;  ma_addr_o <= ma_addr_next;
            ma_mode_o <= ma_mode_next;  ma_size_o <= ma_size_next;  ma_data_o <= ma_data_next;
            wb_src_o <= wb_src_next;  wb_data_o <= wb_data_next;  wb_valid_o <= wb_valid_next;
        end
    end
endmodule

// File: tb/tb_cpu_ex_md.sv
// Bench for cpu_ex_md: two instances (MD_STEP 1 and 4) share stimulus and are
// compared against an arithmetic reference model.
module tb_cpu_ex_md;
    import cpu_ex_md_pkg::*;

    localparam logic [31:0] NOP_PC = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni, valid_i, flush_i, md_en_i, wb_valid_i, ready_i;
    logic [31:0] pc_i, ir_i, alu_op1_i, alu_op2_i, ma_data_i, wb_data_i;
    logic [2:0]  md_op_i;
    alu_mode_t   alu_mode_i;
    ma_mode_t    ma_mode_i;
    ma_size_t    ma_size_i;
    wb_src_t     wb_src_i;

    logic        ready_o_w[2], wb_ready_w[2], wb_valid_async_w[2], empty_w[2], valid_o_w[2], wb_valid_w[2];
    logic [4:0]  wb_addr_w[2];
    logic [31:0] wb_data_async_w[2], pc_o_w[2], ir_o_w[2], ma_addr_w[2], ma_data_w[2], wb_data_w[2];
    ma_mode_t    ma_mode_w[2];
    ma_size_t    ma_size_w[2];
    wb_src_t     wb_src_w[2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        cpu_ex_md #(.XLEN(32), .MD_STEP(gi == 0 ? 1 : 4), .NOP_PC(NOP_PC)) u_dut (
            .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o_w[gi]),
            .flush_i(flush_i), .pc_i(pc_i), .ir_i(ir_i), .alu_op1_i(alu_op1_i), .alu_op2_i(alu_op2_i),
            .alu_mode_i(alu_mode_i), .md_en_i(md_en_i), .md_op_i(md_op_i), .ma_mode_i(ma_mode_i),
            .ma_size_i(ma_size_i), .ma_data_i(ma_data_i), .wb_src_i(wb_src_i), .wb_data_i(wb_data_i),
            .wb_valid_i(wb_valid_i), .wb_addr_async_o(wb_addr_w[gi]), .wb_data_async_o(wb_data_async_w[gi]),
            .wb_ready_async_o(wb_ready_w[gi]), .wb_valid_async_o(wb_valid_async_w[gi]),
            .empty_async_o(empty_w[gi]), .valid_o(valid_o_w[gi]), .ready_i(ready_i),
            .pc_o(pc_o_w[gi]), .ir_o(ir_o_w[gi]), .ma_addr_o(ma_addr_w[gi]), .ma_mode_o(ma_mode_w[gi]),
            .ma_size_o(ma_size_w[gi]), .ma_data_o(ma_data_w[gi]), .wb_src_o(wb_src_w[gi]),
            .wb_data_o(wb_data_w[gi]), .wb_valid_o(wb_valid_w[gi])
        );
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] pc_cnt = 32'h0000_1000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] alu_model(input alu_mode_t m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ps;
        logic [63:0] ua, ub, pu;
        logic ovf;
        sa = $signed(a);  sb = $signed(b);
        ua = {32'd0, a};  ub = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin pu = ua * ub; return pu[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * $signed(ub); return ps[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                ps = sa / sb; return ps[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                ps = sa % sb; return ps[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic md, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int step);
        if (!md) return 0;
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 32 / step + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int budget = 0;
        while (!(ready_o_w[0] && ready_o_w[1]) && budget < 200) begin
            tick();
            budget++;
        end
        check({tag, "_ready_timeout"}, 64'(budget < 200), 64'd1);
    endtask

    task automatic drive(input logic md, input logic [2:0] op, input alu_mode_t am,
                         input logic [31:0] a, input logic [31:0] b, input ma_mode_t mm);
        pc_cnt += 32'd4;
        pc_i = pc_cnt;  ir_i = $urandom;  alu_op1_i = a;  alu_op2_i = b;  alu_mode_i = am;
        md_en_i = md;  md_op_i = op;  ma_mode_i = mm;  ma_data_i = $urandom;
        wb_src_i = WB_SRC_ALU;  wb_data_i = $urandom;  wb_valid_i = 1'b1;  valid_i = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic md, input logic [2:0] op, input alu_mode_t am,
                          input logic [31:0] a, input logic [31:0] b, input ma_mode_t mm);
        logic [31:0] e_alu, e_res, e_addr, got_res[2], got_addr[2];
        logic seen[2];
        int lat[2];
        int k;
        e_alu  = alu_model(am, a, b);
        e_res  = md ? md_model(op, a, b) : e_alu;
        e_addr = (mm != MA_X) ? e_alu : 32'd0;
        wait_ready(tag);
        drive(md, op, am, a, b, mm);
        #1;
        for (int i = 0; i < 2; i++) begin
            check({tag, "_fwd_addr"}, 64'(wb_addr_w[i]), 64'(ir_i[11:7]));
            check({tag, "_fwd_valid"}, 64'(wb_valid_async_w[i]), 64'd1);
            check({tag, "_empty"}, 64'(empty_w[i]), 64'd0);
            if (!md) begin
                check({tag, "_fwd_ready"}, 64'(wb_ready_w[i]), 64'd1);
                check({tag, "_fwd_data"}, 64'(wb_data_async_w[i]), 64'(e_alu));
            end
        end
        tick();
        valid_i = 1'b0;
        seen[0] = 1'b0;  seen[1] = 1'b0;  lat[0] = -1;  lat[1] = -1;
        got_res[0] = '0;  got_res[1] = '0;  got_addr[0] = '0;  got_addr[1] = '0;
        k = 0;
        while (1) begin
            for (int i = 0; i < 2; i++) begin
                if (!seen[i] && valid_o_w[i] && pc_o_w[i] == pc_cnt) begin
                    seen[i] = 1'b1;  lat[i] = k;
                    got_res[i] = wb_data_w[i];  got_addr[i] = ma_addr_w[i];
                end
            end
            if ((seen[0] && seen[1]) || k >= 100) break;
            tick();
            k++;
        end
        for (int i = 0; i < 2; i++) begin
            check({tag, "_done"}, 64'(seen[i]), 64'd1);
            check({tag, "_res"}, 64'(got_res[i]), 64'(e_res));
            check({tag, "_lat"}, 64'(lat[i]), 64'(exp_lat(md, op, a, b, i == 0 ? 1 : 4)));
            check({tag, "_maddr"}, 64'(got_addr[i]), 64'(e_addr));
        end
        $display("op %s md=%0d op=%0d a=%h b=%h exp=%h got=%h/%h lat=%0d/%0d",
                 tag, md, op, a, b, e_res, got_res[0], got_res[1], lat[0], lat[1]);
    endtask

    task automatic check_bubble(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_valid"}, 64'(valid_o_w[i]), 64'd0);
            check({tag, "_pc"}, 64'(pc_o_w[i]), 64'(NOP_PC));
        end
    endtask

    initial begin
        rst_ni = 1'b0;  valid_i = 1'b0;  flush_i = 1'b0;  ready_i = 1'b1;
        pc_i = NOP_PC;  ir_i = NOP_IR;  alu_op1_i = '0;  alu_op2_i = '0;  alu_mode_i = ALU_ADD;
        md_en_i = 1'b0;  md_op_i = '0;  ma_mode_i = MA_X;  ma_size_i = MA_W;  ma_data_i = '0;
        wb_src_i = WB_SRC_ALU;  wb_data_i = '0;  wb_valid_i = 1'b0;
        repeat (3) tick();
        check_bubble("reset");
        for (int i = 0; i < 2; i++) begin
            check("reset_ir", 64'(ir_o_w[i]), 64'(NOP_IR));
            check("reset_wbdata", 64'(wb_data_w[i]), 64'd0);
            check("reset_wbvalid", 64'(wb_valid_w[i]), 64'd0);
            check("reset_mamode", 64'(ma_mode_w[i]), 64'(MA_X));
        end
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            check("idle_ready", 64'(ready_o_w[i]), 64'd1);
            check("idle_empty", 64'(empty_w[i]), 64'd1);
        end

        run_op("mul_7x6",    1, 3'd0, ALU_ADD, 32'd7, 32'd6, MA_X);
        run_op("div_m7_2",   1, 3'd4, ALU_ADD, 32'hFFFF_FFF9, 32'd2, MA_X);
        run_op("rem_m7_2",   1, 3'd6, ALU_ADD, 32'hFFFF_FFF9, 32'd2, MA_X);
        run_op("divu_max_2", 1, 3'd5, ALU_ADD, 32'hFFFF_FFFF, 32'd2, MA_X);
        run_op("div_5_0",    1, 3'd4, ALU_ADD, 32'd5, 32'd0, MA_X);
        run_op("rem_5_0",    1, 3'd6, ALU_ADD, 32'd5, 32'd0, MA_X);
        run_op("div_ovf",    1, 3'd4, ALU_ADD, 32'h8000_0000, 32'hFFFF_FFFF, MA_X);
        run_op("rem_ovf",    1, 3'd6, ALU_ADD, 32'h8000_0000, 32'hFFFF_FFFF, MA_X);
        run_op("mulh_min",   1, 3'd1, ALU_ADD, 32'h8000_0000, 32'h8000_0000, MA_X);
        run_op("mulhu_max",  1, 3'd3, ALU_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MA_X);
        run_op("mulhsu_m1",  1, 3'd2, ALU_ADD, 32'hFFFF_FFFF, 32'd2, MA_X);
        run_op("add_ld",     0, 3'd0, ALU_ADD, 32'd100, 32'd24, MA_LD);

        // Back-pressure: hold ready_i low for 5 cycles behind an ADD result.
        begin
            logic [31:0] pc_first;
            wait_ready("bp");
            drive(0, 3'd0, ALU_ADD, 32'd1, 32'd2, MA_X);
            pc_first = pc_cnt;
            tick();
            ready_i = 1'b0;
            drive(0, 3'd0, ALU_ADD, 32'd10, 32'd20, MA_X);
            for (int c = 0; c < 5; c++) begin
                #1;
                for (int i = 0; i < 2; i++) begin
                    check("bp_hold_pc", 64'(pc_o_w[i]), 64'(pc_first));
                    check("bp_hold_data", 64'(wb_data_w[i]), 64'd3);
                    check("bp_hold_valid", 64'(valid_o_w[i]), 64'd1);
                    check("bp_ready_low", 64'(ready_o_w[i]), 64'd0);
                end
                tick();
            end
            ready_i = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) check("bp_ready_back", 64'(ready_o_w[i]), 64'd1);
            tick();
            valid_i = 1'b0;
            for (int i = 0; i < 2; i++) begin
                check("bp_next_pc", 64'(pc_o_w[i]), 64'(pc_cnt));
                check("bp_next_data", 64'(wb_data_w[i]), 64'd30);
            end
            $display("op backpressure add 10+20 got=%h/%h", wb_data_w[0], wb_data_w[1]);
        end

        // Flush on BUSY cycle 10 of a DIV.
        wait_ready("fl");
        drive(1, 3'd4, ALU_ADD, 32'd100, 32'd7, MA_X);
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_bubble("flush");
        for (int i = 0; i < 2; i++) check("flush_ready", 64'(ready_o_w[i]), 64'd1);
        $display("op flush during div valid=%0d/%0d", valid_o_w[0], valid_o_w[1]);
        run_op("add_after_flush", 0, 3'd0, ALU_ADD, 32'd3, 32'd4, MA_X);

        // Asynchronous reset pulse in the middle of a MUL.
        wait_ready("rs");
        drive(1, 3'd0, ALU_ADD, 32'd7, 32'd6, MA_X);
        tick();
        valid_i = 1'b0;
        repeat (5) tick();
        #2 rst_ni = 1'b0;
        #1;
        check_bubble("rst_async");
        tick();
        rst_ni = 1'b1;
        tick();
        check_bubble("rst_release");
        for (int i = 0; i < 2; i++) check("rst_ready", 64'(ready_o_w[i]), 64'd1);
        $display("op reset during mul valid=%0d/%0d", valid_o_w[0], valid_o_w[1]);
        run_op("add_after_rst", 0, 3'd0, ALU_ADD, 32'd3, 32'd4, MA_X);

        for (int t = 0; t < 60; t++) begin
            run_op($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   alu_mode_t'($urandom_range(0, 9)), pick(), pick(), ma_mode_t'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
